// File: rtl/ft_supervisor_pkg.sv
// Shared types for the FT supervisor: event, health and command encodings,
// plus the replica popcount used by both event capture and health tracking.
package ft_supervisor_pkg;

    localparam int NUM_EVT_TYPES = 4;

    typedef enum logic [1:0] {
        EVT_CORRECTED      = 2'b00,
        EVT_UNCORRECTED    = 2'b01,
        EVT_REPLICA_BROKEN = 2'b10,
        EVT_FATAL          = 2'b11
    } ft_evt_e;

    typedef enum logic [1:0] {
        HEALTH_NORMAL   = 2'b00,
        HEALTH_DEGRADED = 2'b01,
        HEALTH_FATAL    = 2'b10
    } ft_health_e;

    typedef enum logic [1:0] {
        CMD_NOP      = 2'b00,
        CMD_SET_MASK = 2'b01,
        CMD_CLR_MASK = 2'b10,
        CMD_CLR_OVF  = 2'b11
    } ft_cmd_e;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/ft_supervisor_evt_fifo.sv
// Synchronous event FIFO without fall-through; a push while full is accepted
// only when a pop frees the head slot in the same cycle.
module ft_evt_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW:0]       wr_ptr;
    logic [PW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= wr_data;
    end

    // Storage is not reset, so the head reads as zero whenever nothing is queued.
    assign rd_data = empty ? '0 : mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/ft_supervisor.sv
// Supervisor for triplicated FT units: latches error events, serialises them
// round-robin into an event FIFO, owns the set_broken masks and tracks health.
module ft_supervisor
    import ft_supervisor_pkg::*;
#(
    parameter  int NUNITS     = 4,
    parameter  int FIFO_DEPTH = 4,
    parameter  int OVF_W      = 8,
    localparam int UW         = $clog2(NUNITS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUNITS-1:0]   unit_err_detected_i,
    input  logic [NUNITS-1:0]   unit_err_corrected_i,
    input  logic [3*NUNITS-1:0] unit_is_broken_i,
    output logic [3*NUNITS-1:0] unit_set_broken_o,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [UW-1:0]       cmd_unit_i,
    input  logic [1:0]          cmd_op_i,
    input  logic [2:0]          cmd_mask_i,
    output logic                evt_valid_o,
    input  logic                evt_ready_i,
    output logic [UW-1:0]       evt_unit_o,
    output logic [1:0]          evt_type_o,
    output logic [1:0]          state_o,
    output logic [OVF_W-1:0]    ovf_cnt_o
);

    localparam int NT = NUM_EVT_TYPES;
    localparam int CW = $clog2(NUNITS * NT + 1);
    localparam int SW = OVF_W + CW + 1;

    function automatic logic [OVF_W-1:0] sat_add(input logic [OVF_W-1:0] base,
                                                 input logic [CW-1:0]    inc);
        logic [SW-1:0] sum;
        sum = SW'(base) + SW'(inc);
        if (sum[SW-1:OVF_W] != '0) return {OVF_W{1'b1}};
        return sum[OVF_W-1:0];
    endfunction

    logic [NUNITS-1:0][2:0]    broken_cur;
    logic [NUNITS-1:0][2:0]    broken_p0;
    logic [NUNITS-1:0][2:0]    mask_p0;
    logic [NUNITS-1:0][NT-1:0] occ;
    logic [NUNITS-1:0][NT-1:0] clr;
    logic [NUNITS-1:0][NT-1:0] pend_p0;
    logic [NUNITS-1:0][NT-1:0] pend_nxt;
    logic [UW-1:0]             last_p0;
    logic [UW-1:0]             grant_u;
    ft_evt_e                   grant_t;
    logic                      found;
    logic                      push_en;
    logic                      evt_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [UW+1:0]             fifo_rd;
    logic [CW-1:0]             ovf_inc;
    logic [OVF_W-1:0]          ovf_p0;
    logic                      any_one;
    logic                      any_two;
    ft_health_e                state_p0;
    ft_cmd_e                   cmd_op;
    logic                      cmd_hit;
    logic                      ovf_clr;

    assign broken_cur = unit_is_broken_i;
    assign cmd_op     = ft_cmd_e'(cmd_op_i);
    assign cmd_hit    = cmd_valid_i && (int'(cmd_unit_i) < NUNITS);
    assign ovf_clr    = cmd_hit && (cmd_op == CMD_CLR_OVF);

    // p0: per-unit event capture against the registered is_broken history
    always_comb begin
        occ = '0;
        any_one = 1'b0;
        any_two = 1'b0;
        for (int u = 0; u < NUNITS; u++) begin
            occ[u][EVT_CORRECTED]      = unit_err_detected_i[u] && unit_err_corrected_i[u];
            occ[u][EVT_UNCORRECTED]    = unit_err_detected_i[u] && !unit_err_corrected_i[u];
            occ[u][EVT_REPLICA_BROKEN] = |(broken_cur[u] & ~broken_p0[u]);
            occ[u][EVT_FATAL]          = (popcount3(broken_cur[u]) >= 2'd2) &&
                                         (popcount3(broken_p0[u]) < 2'd2);
            if (popcount3(broken_cur[u]) == 2'd1)      any_one = 1'b1;
            else if (popcount3(broken_cur[u]) >= 2'd2) any_two = 1'b1;
        end
    end

    // p1: round-robin unit pick, then fixed type priority within the unit
    always_comb begin
        found   = 1'b0;
        grant_u = '0;
        for (int i = 1; i <= NUNITS; i++) begin
            if (!found && (|pend_p0[(int'(last_p0) + i) % NUNITS])) begin
                found   = 1'b1;
                grant_u = UW'((int'(last_p0) + i) % NUNITS);
            end
        end
        grant_t = EVT_CORRECTED;
        if (pend_p0[grant_u][EVT_FATAL])               grant_t = EVT_FATAL;
        else if (pend_p0[grant_u][EVT_REPLICA_BROKEN]) grant_t = EVT_REPLICA_BROKEN;
        else if (pend_p0[grant_u][EVT_UNCORRECTED])    grant_t = EVT_UNCORRECTED;
    end

    assign evt_pop = evt_valid_o && evt_ready_i;
    assign push_en = found && (!fifo_full || evt_pop);

    // A fresh occurrence beats the clear of the same pending bit and is not a drop.
    always_comb begin
        clr = '0;
        if (push_en) clr[grant_u][grant_t] = 1'b1;
        ovf_inc = '0;
        for (int u = 0; u < NUNITS; u++) begin
            for (int t = 0; t < NT; t++) begin
                if (occ[u][t] && pend_p0[u][t] && !clr[u][t]) ovf_inc = ovf_inc + 1'b1;
            end
        end
        pend_nxt = (pend_p0 & ~clr) | occ;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            broken_p0 <= '0;
            pend_p0   <= '0;
            mask_p0   <= '0;
            last_p0   <= UW'(NUNITS - 1);
            ovf_p0    <= '0;
            state_p0  <= HEALTH_NORMAL;
        end else begin
            broken_p0 <= broken_cur;
            pend_p0   <= pend_nxt;
            if (push_en) last_p0 <= grant_u;
            if (cmd_hit) begin
                case (cmd_op)
                    CMD_SET_MASK: mask_p0[cmd_unit_i] <= mask_p0[cmd_unit_i] | cmd_mask_i;
                    CMD_CLR_MASK: mask_p0[cmd_unit_i] <= mask_p0[cmd_unit_i] & ~cmd_mask_i;
                    default:      ;
                endcase
            end
            ovf_p0 <= sat_add(ovf_clr ? '0 : ovf_p0, ovf_inc);
            case (state_p0)
                HEALTH_NORMAL: begin
                    if (any_two)      state_p0 <= HEALTH_FATAL;
                    else if (any_one) state_p0 <= HEALTH_DEGRADED;
                end
                HEALTH_DEGRADED: begin
                    if (any_two)       state_p0 <= HEALTH_FATAL;
                    else if (!any_one) state_p0 <= HEALTH_NORMAL;
                end
                HEALTH_FATAL: ;
                default:      state_p0 <= HEALTH_NORMAL;
            endcase
        end
    end

    ft_evt_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (UW + 2)
    ) u_evt_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_en),
        .pop     (evt_pop),
        .wr_data ({grant_u, grant_t}),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign evt_valid_o       = !fifo_empty;
    assign evt_unit_o        = fifo_rd[UW+1:2];
    assign evt_type_o        = fifo_rd[1:0];
    assign unit_set_broken_o = mask_p0;
    assign state_o           = state_p0;
    assign ovf_cnt_o         = ovf_p0;
    assign cmd_ready_o       = 1'b1;

endmodule

// File: tb/tb_ft_supervisor.sv
// Bench for ft_supervisor: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based behavioural model.
module tb_ft_supervisor;

    localparam int NU    = 5;
    localparam int DEPTH = 4;
    localparam int OW    = 8;
    localparam int UWB   = $clog2(NU);
    localparam int OMAX  = (1 << OW) - 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NU-1:0]       unit_err_detected_i = '0;
    logic [NU-1:0]       unit_err_corrected_i = '0;
    logic [3*NU-1:0]     unit_is_broken_i = '0;
    logic [3*NU-1:0]     unit_set_broken_o;
    logic                cmd_valid_i = 1'b0;
    logic                cmd_ready_o;
    logic [UWB-1:0]      cmd_unit_i = '0;
    logic [1:0]          cmd_op_i = '0;
    logic [2:0]          cmd_mask_i = '0;
    logic                evt_valid_o;
    logic                evt_ready_i = 1'b1;
    logic [UWB-1:0]      evt_unit_o;
    logic [1:0]          evt_type_o;
    logic [1:0]          state_o;
    logic [OW-1:0]       ovf_cnt_o;

    ft_supervisor #(.NUNITS(NU), .FIFO_DEPTH(DEPTH), .OVF_W(OW)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .unit_err_detected_i  (unit_err_detected_i),
        .unit_err_corrected_i (unit_err_corrected_i),
        .unit_is_broken_i     (unit_is_broken_i),
        .unit_set_broken_o    (unit_set_broken_o),
        .cmd_valid_i          (cmd_valid_i),
        .cmd_ready_o          (cmd_ready_o),
        .cmd_unit_i           (cmd_unit_i),
        .cmd_op_i             (cmd_op_i),
        .cmd_mask_i           (cmd_mask_i),
        .evt_valid_o          (evt_valid_o),
        .evt_ready_i          (evt_ready_i),
        .evt_unit_o           (evt_unit_o),
        .evt_type_o           (evt_type_o),
        .state_o              (state_o),
        .ovf_cnt_o            (ovf_cnt_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Behavioural model: pending flags per (unit,type), queue of unit*4+type.
    bit         m_pend [NU][4];
    int         m_last;
    int         m_q [$];
    logic [2:0] m_prev [NU];
    logic [2:0] m_mask [NU];
    int         m_ovf;
    int         m_state;

    task automatic m_reset();
        m_q.delete();
        m_last  = NU - 1;
        m_ovf   = 0;
        m_state = 0;
        for (int u = 0; u < NU; u++) begin
            m_prev[u] = '0;
            m_mask[u] = '0;
            for (int t = 0; t < 4; t++) m_pend[u][t] = 1'b0;
        end
    endtask

    task automatic m_step();
        bit   pop, push, cleared, occ;
        int   gu, gt, n, maxb, cnt;
        logic [2:0] b;
        pop  = (m_q.size() > 0) && evt_ready_i;
        push = 1'b0;
        gu   = 0;
        gt   = 0;
        for (int k = 1; k <= NU; k++) begin
            int u;
            u = (m_last + k) % NU;
            if (!push && (m_pend[u][0] || m_pend[u][1] || m_pend[u][2] || m_pend[u][3])) begin
                push = 1'b1;
                gu   = u;
            end
        end
        if (push) begin
            for (int t = 3; t >= 0; t--) begin
                if (m_pend[gu][t]) begin
                    gt = t;
                    break;
                end
            end
        end
        if (push && m_q.size() >= DEPTH && !pop) push = 1'b0;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            m_q.push_back(gu * 4 + gt);
            m_last = gu;
        end
        n    = 0;
        maxb = 0;
        for (int u = 0; u < NU; u++) begin
            b   = unit_is_broken_i[3*u +: 3];
            cnt = $countones(b);
            if (cnt > maxb) maxb = cnt;
            for (int t = 0; t < 4; t++) begin
                case (t)
                    0:       occ = unit_err_detected_i[u] && unit_err_corrected_i[u];
                    1:       occ = unit_err_detected_i[u] && !unit_err_corrected_i[u];
                    2:       occ = (b & ~m_prev[u]) != 3'b000;
                    default: occ = (cnt >= 2) && ($countones(m_prev[u]) < 2);
                endcase
                cleared = push && (gu == u) && (gt == t);
                if (occ && m_pend[u][t] && !cleared) n++;
                m_pend[u][t] = (m_pend[u][t] && !cleared) || occ;
            end
            m_prev[u] = b;
        end
        if (cmd_valid_i && int'(cmd_unit_i) < NU) begin
            case (cmd_op_i)
                2'b01: m_mask[cmd_unit_i] = m_mask[cmd_unit_i] | cmd_mask_i;
                2'b10: m_mask[cmd_unit_i] = m_mask[cmd_unit_i] & ~cmd_mask_i;
                2'b11: m_ovf = 0;
                default: ;
            endcase
        end
        m_ovf = m_ovf + n;
        if (m_ovf > OMAX) m_ovf = OMAX;
        if (m_state != 2) begin
            if (maxb >= 2)         m_state = 2;
            else if (maxb == 1)    m_state = 1;
            else if (m_state == 1) m_state = 0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_reset();
        else        m_step();
    end

    task automatic check_all();
        logic [3*NU-1:0] m;
        for (int u = 0; u < NU; u++) m[3*u +: 3] = m_mask[u];
        chk("evt_valid", 32'(evt_valid_o), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk("evt_unit", 32'(evt_unit_o), 32'(m_q[0] / 4));
            chk("evt_type", 32'(evt_type_o), 32'(m_q[0] % 4));
        end
        chk("state", 32'(state_o), 32'(m_state));
        chk("ovf_cnt", 32'(ovf_cnt_o), 32'(m_ovf));
        chk("set_broken", 32'(unit_set_broken_o), 32'(m));
        chk("cmd_ready", 32'(cmd_ready_o), 32'd1);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        unit_err_detected_i  = '0;
        unit_err_corrected_i = '0;
        cmd_valid_i          = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        unit_is_broken_i = '0;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic do_cmd(input int unit, input logic [1:0] op, input logic [2:0] mask);
        cmd_valid_i = 1'b1;
        cmd_unit_i  = UWB'(unit);
        cmd_op_i    = op;
        cmd_mask_i  = mask;
        cyc();
        cmd_valid_i = 1'b0;
    endtask

    initial begin
        cyc();
        cyc();
        chk("rst_valid", 32'(evt_valid_o), 32'd0);
        chk("rst_unit", 32'(evt_unit_o), 32'd0);
        chk("rst_type", 32'(evt_type_o), 32'd0);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_ovf", 32'(ovf_cnt_o), 32'd0);
        chk("rst_mask", 32'(unit_set_broken_o), 32'd0);
        chk("rst_ready", 32'(cmd_ready_o), 32'd1);
        rst_n = 1'b1;

        // corrected event on unit 2, two-cycle latency
        evt_ready_i = 1'b0;
        unit_err_detected_i[2]  = 1'b1;
        unit_err_corrected_i[2] = 1'b1;
        cyc();
        idle();
        chk("corr_lat1", 32'(evt_valid_o), 32'd0);
        cyc();
        chk("corr_valid", 32'(evt_valid_o), 32'd1);
        chk("corr_unit", 32'(evt_unit_o), 32'd2);
        chk("corr_type", 32'(evt_type_o), 32'd0);
        evt_ready_i = 1'b1;
        cyc();
        chk("corr_pop", 32'(evt_valid_o), 32'd0);
        chk("corr_state", 32'(state_o), 32'd0);

        // round-robin
        do_reset();
        unit_err_detected_i = 5'b01011;
        cyc();
        idle();
        cyc();
        chk("rr_a", 32'(evt_unit_o), 32'd0);
        chk("rr_a_type", 32'(evt_type_o), 32'd1);
        cyc();
        chk("rr_b", 32'(evt_unit_o), 32'd1);
        cyc();
        chk("rr_c", 32'(evt_unit_o), 32'd3);
        unit_err_detected_i = 5'b01001;
        cyc();
        idle();
        cyc();
        chk("rr_d", 32'(evt_unit_o), 32'd0);
        cyc();
        chk("rr_e", 32'(evt_unit_o), 32'd3);
        cyc();
        chk("rr_empty", 32'(evt_valid_o), 32'd0);

        // degrade then fatal on unit 1
        unit_is_broken_i[5:3] = 3'b001;
        cyc();
        chk("deg_state", 32'(state_o), 32'd1);
        cyc();
        chk("deg_evt", 32'({evt_valid_o, evt_unit_o, evt_type_o}), 32'({1'b1, 3'd1, 2'd2}));
        cyc();
        evt_ready_i = 1'b0;
        unit_is_broken_i[5:3]   = 3'b011;
        unit_err_detected_i[1]  = 1'b1;
        unit_err_corrected_i[1] = 1'b1;
        cyc();
        idle();
        chk("fat_state", 32'(state_o), 32'd2);
        cyc();
        chk("fat_evt", 32'({evt_valid_o, evt_unit_o, evt_type_o}), 32'({1'b1, 3'd1, 2'd3}));
        cyc();
        cyc();
        evt_ready_i = 1'b1;
        cyc();
        chk("fat_rb", 32'(evt_type_o), 32'd2);
        cyc();
        chk("fat_corr", 32'(evt_type_o), 32'd0);
        unit_is_broken_i = '0;
        repeat (3) cyc();
        chk("fat_sticky", 32'(state_o), 32'd2);

        // commands
        do_cmd(3, 2'b01, 3'b101);
        chk("set_mask", 32'(unit_set_broken_o[11:9]), 32'd5);
        do_cmd(3, 2'b10, 3'b001);
        chk("clr_mask", 32'(unit_set_broken_o[11:9]), 32'd4);
        do_cmd(5, 2'b01, 3'b111);
        chk("bad_unit5", 32'(unit_set_broken_o), 32'h800);
        do_cmd(7, 2'b10, 3'b111);
        chk("bad_unit7", 32'(unit_set_broken_o), 32'h800);
        do_cmd(3, 2'b00, 3'b111);
        chk("nop", 32'(unit_set_broken_o), 32'h800);

        // overflow with FIFO full
        do_reset();
        evt_ready_i = 1'b0;
        unit_err_detected_i = 5'b11110;
        cyc();
        idle();
        repeat (5) cyc();
        for (int k = 0; k < 3; k++) begin
            unit_err_detected_i[0]  = 1'b1;
            unit_err_corrected_i[0] = 1'b1;
            cyc();
            idle();
            cyc();
        end
        chk("ovf_two", 32'(ovf_cnt_o), 32'd2);
        chk("ovf_head", 32'({evt_valid_o, evt_unit_o, evt_type_o}), 32'({1'b1, 3'd1, 2'd1}));
        do_cmd(0, 2'b11, 3'b000);
        chk("ovf_clr", 32'(ovf_cnt_o), 32'd0);
        unit_err_detected_i[0]  = 1'b1;
        unit_err_corrected_i[0] = 1'b1;
        do_cmd(0, 2'b11, 3'b000);
        idle();
        chk("ovf_clr_hit", 32'(ovf_cnt_o), 32'd1);
        unit_err_detected_i = '1;
        repeat (80) cyc();
        idle();
        chk("ovf_sat", 32'(ovf_cnt_o), 32'(OMAX));
        evt_ready_i = 1'b1;
        repeat (20) cyc();
        chk("drained", 32'(evt_valid_o), 32'd0);

        // asynchronous reset with queued events
        evt_ready_i = 1'b0;
        do_cmd(0, 2'b01, 3'b111);
        unit_is_broken_i[8:6] = 3'b001;
        unit_err_detected_i = 5'b01001;
        cyc();
        idle();
        repeat (4) cyc();
        chk("pre_rst_valid", 32'(evt_valid_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(evt_valid_o), 32'd0);
        chk("arst_mask", 32'(unit_set_broken_o), 32'd0);
        chk("arst_state", 32'(state_o), 32'd0);
        chk("arst_ovf", 32'(ovf_cnt_o), 32'd0);
        unit_is_broken_i = '0;
        @(negedge clk);
        cyc();
        rst_n = 1'b1;
        evt_ready_i = 1'b1;
        cyc();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (c % 600 == 599) do_reset();
            unit_err_detected_i  = ($urandom_range(0, 2) == 0) ? NU'($urandom) : '0;
            unit_err_corrected_i = NU'($urandom);
            for (int u = 0; u < NU; u++) begin
                if ($urandom_range(0, 29) == 0) begin
                    int r;
                    r = $urandom_range(0, 9);
                    if (r < 5)      unit_is_broken_i[3*u +: 3] = 3'b000;
                    else if (r < 9) unit_is_broken_i[3*u +: 3] = 3'b001 << $urandom_range(0, 2);
                    else            unit_is_broken_i[3*u +: 3] = 3'($urandom);
                end
            end
            evt_ready_i = ((c / 64) % 4 == 3) ? 1'b0 : 1'($urandom_range(0, 1));
            cmd_valid_i = ($urandom_range(0, 3) == 0);
            cmd_unit_i  = UWB'($urandom_range(0, 7));
            cmd_op_i    = 2'($urandom);
            cmd_mask_i  = 3'($urandom);
            cyc();
        end
        idle();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
